// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: runs one FFT per audio frame.
// It loads real samples from the input frame buffer into fft_controller and
// pulses start. It then waits for done and streams the results into the output
// buffer that feeds SPI. Control outputs are registered. The two data buses are
// gated copies of the 1-cycle-latency read data.
module fft_frame_sequencer #(
    parameter int N_LOG2  = 6,
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_frame_valid,
    output logic                 o_frame_ack,
    output logic [N_LOG2-1:0]    o_in_adr,
    input  logic [WIDTH-1:0]     i_in_data,
    output logic                 o_fft_load,
    output logic                 o_fft_start,
    output logic [N_LOG2-1:0]    o_fft_adr,
    output logic [2*WIDTH-1:0]   o_fft_rd,
    input  logic                 i_fft_done,
    input  logic [2*WIDTH-1:0]   i_fft_wd,
    input  logic                 i_out_ready,
    output logic                 o_out_we,
    output logic [N_LOG2-1:0]    o_out_adr,
    output logic [2*WIDTH-1:0]   o_out_data,
    output logic                 o_frame_done,
    output logic                 o_busy,
    output logic                 o_err
);

    // Counter carries one extra bit so the terminal value 2^N_LOG2 is visible
    // without wrapping into the next frame.
    localparam int CW = N_LOG2 + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_START  = 3'd2,
        S_WAIT   = 3'd3,
        S_HOLD   = 3'd4,
        S_UNLOAD = 3'd5,
        S_FIN    = 3'd6
    } state_t;

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [TW-1:0]       r_timer;
    logic                r_err;
    logic                r_frame_ack;
    logic [N_LOG2-1:0]   r_in_adr;
    logic                r_fft_load;
    logic                r_fft_start;
    logic [N_LOG2-1:0]   r_fft_adr;
    logic                r_out_we;
    logic [N_LOG2-1:0]   r_out_adr;
    logic                r_frame_done;
    logic                r_busy;

    state_t              w_state_nxt;
    logic [CW-1:0]       w_cnt_nxt;
    logic [CW-1:0]       w_cnt_inc;
    logic [TW-1:0]       w_timer_nxt;
    logic                w_err_nxt;
    logic                w_frame_ack_nxt;
    logic [N_LOG2-1:0]   w_in_adr_nxt;
    logic                w_fft_load_nxt;
    logic                w_fft_start_nxt;
    logic [N_LOG2-1:0]   w_fft_adr_nxt;
    logic                w_out_we_nxt;
    logic [N_LOG2-1:0]   w_out_adr_nxt;
    logic                w_frame_done_nxt;
    logic                w_busy_nxt;

    assign w_cnt_inc = r_cnt + CW'(1);

    // Next-state logic; output registers are loaded with the value they must show in the next state.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_timer_nxt      = r_timer;
        w_err_nxt        = r_err;
        w_frame_ack_nxt  = 1'b0;
        w_in_adr_nxt     = {N_LOG2{1'b0}};
        w_fft_load_nxt   = 1'b0;
        w_fft_start_nxt  = 1'b0;
        w_fft_adr_nxt    = {N_LOG2{1'b0}};
        w_out_we_nxt     = 1'b0;
        w_out_adr_nxt    = {N_LOG2{1'b0}};
        w_frame_done_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A timed-out FFT parks the sequencer here until reset.
                if (i_frame_valid && !r_err) begin
                    w_state_nxt = S_LOAD;
                    w_cnt_nxt   = {CW{1'b0}};
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LOAD: begin
                // Address cnt goes out now; its sample is forwarded to the FFT one cycle later.
                if (!r_cnt[N_LOG2]) begin
                    w_cnt_nxt      = w_cnt_inc;
                    w_in_adr_nxt   = w_cnt_inc[N_LOG2-1:0];
                    w_fft_load_nxt = 1'b1;
                    w_fft_adr_nxt  = r_cnt[N_LOG2-1:0];
                end else begin
                    w_state_nxt     = S_START;
                    w_cnt_nxt       = {CW{1'b0}};
                    w_timer_nxt     = {TW{1'b0}};
                    w_fft_start_nxt = 1'b1;
                    w_frame_ack_nxt = 1'b1;
                end
            end
            S_START: begin
                // The timer counts from the start cycle, so the timeout is measured from fft_start.
                w_state_nxt = S_WAIT;
                w_timer_nxt = r_timer + TW'(1);
            end
            S_WAIT: begin
                // Done takes priority over a timeout landing in the same cycle.
                if (i_fft_done) begin
                    w_state_nxt = S_HOLD;
                end else if (r_timer == TMR_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            S_HOLD: begin
                if (i_out_ready) begin
                    w_state_nxt   = S_UNLOAD;
                    w_cnt_nxt     = {CW{1'b0}};
                    w_fft_adr_nxt = {N_LOG2{1'b0}};
                end else begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_UNLOAD: begin
                // out_ready and fft_done are deliberately ignored until the frame is written.
                if (!r_cnt[N_LOG2]) begin
                    w_cnt_nxt     = w_cnt_inc;
                    w_fft_adr_nxt = w_cnt_inc[N_LOG2-1:0];
                    w_out_we_nxt  = 1'b1;
                    w_out_adr_nxt = r_cnt[N_LOG2-1:0];
                end else begin
                    w_state_nxt      = S_FIN;
                    w_cnt_nxt        = {CW{1'b0}};
                    w_frame_done_nxt = 1'b1;
                end
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = {CW{1'b0}};
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // State, counters, sticky error, and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= {CW{1'b0}};
            r_timer      <= {TW{1'b0}};
            r_err        <= 1'b0;
            r_frame_ack  <= 1'b0;
            r_in_adr     <= {N_LOG2{1'b0}};
            r_fft_load   <= 1'b0;
            r_fft_start  <= 1'b0;
            r_fft_adr    <= {N_LOG2{1'b0}};
            r_out_we     <= 1'b0;
            r_out_adr    <= {N_LOG2{1'b0}};
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_timer      <= w_timer_nxt;
            r_err        <= w_err_nxt;
            r_frame_ack  <= w_frame_ack_nxt;
            r_in_adr     <= w_in_adr_nxt;
            r_fft_load   <= w_fft_load_nxt;
            r_fft_start  <= w_fft_start_nxt;
            r_fft_adr    <= w_fft_adr_nxt;
            r_out_we     <= w_out_we_nxt;
            r_out_adr    <= w_out_adr_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    assign o_frame_ack  = r_frame_ack;
    assign o_in_adr     = r_in_adr;
    assign o_fft_load   = r_fft_load;
    assign o_fft_start  = r_fft_start;
    assign o_fft_adr    = r_fft_adr;
    assign o_out_we     = r_out_we;
    assign o_out_adr    = r_out_adr;
    assign o_frame_done = r_frame_done;
    assign o_busy       = r_busy;
    assign o_err        = r_err;

    // Read data arrives in the strobe cycle, so it is forwarded and gated by the registered strobe.
    always_comb begin
        if (r_fft_load) begin
            o_fft_rd = {i_in_data, {WIDTH{1'b0}}};
        end else begin
            o_fft_rd = {(2*WIDTH){1'b0}};
        end
        if (r_out_we) begin
            o_out_data = i_fft_wd;
        end else begin
            o_out_data = {(2*WIDTH){1'b0}};
        end
    end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer.
// The bench models the input buffer and the FFT result memory. Expected load
// and unload beats go into queues and are popped as the DUT strobes.
module tb_fft_frame_sequencer;

    localparam int N_LOG2  = 6;
    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 4096;
    localparam int NPTS    = 64;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 frame_valid = 1'b0;
    logic                 frame_ack;
    logic [N_LOG2-1:0]    in_adr;
    logic [WIDTH-1:0]     in_data = '0;
    logic                 fft_load;
    logic                 fft_start;
    logic [N_LOG2-1:0]    fft_adr;
    logic [2*WIDTH-1:0]   fft_rd;
    logic                 fft_done = 1'b0;
    logic [2*WIDTH-1:0]   fft_wd = '0;
    logic                 out_ready = 1'b0;
    logic                 out_we;
    logic [N_LOG2-1:0]    out_adr;
    logic [2*WIDTH-1:0]   out_data;
    logic                 frame_done;
    logic                 busy;
    logic                 err;

    int total = 0;
    int bad   = 0;
    int n_load = 0, n_start = 0, n_ack = 0, n_we = 0, n_fdone = 0;
    int ld_base = 0, st_base = 0, ack_base = 0, we_base = 0, fd_base = 0;
    int data_ofs = 0;
    logic [37:0] q_load[$];
    logic [37:0] q_out[$];

    fft_frame_sequencer #(.N_LOG2(N_LOG2), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_frame_valid(frame_valid), .o_frame_ack(frame_ack),
        .o_in_adr(in_adr), .i_in_data(in_data),
        .o_fft_load(fft_load), .o_fft_start(fft_start),
        .o_fft_adr(fft_adr), .o_fft_rd(fft_rd),
        .i_fft_done(fft_done), .i_fft_wd(fft_wd),
        .i_out_ready(out_ready), .o_out_we(out_we),
        .o_out_adr(out_adr), .o_out_data(out_data),
        .o_frame_done(frame_done), .o_busy(busy), .o_err(err)
    );

    always #5 clk = ~clk;

    // Input frame buffer: sample at address a is a + data_ofs, one cycle latency.
    always @(posedge clk) in_data <= 16'(int'(in_adr) + data_ofs);

    // FFT result memory: word at address a is {a, ~a}, one cycle latency.
    always @(posedge clk) fft_wd <= {16'(fft_adr), ~16'(fft_adr)};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Monitor: scoreboard the load/unload beats and count the pulse outputs.
    always @(negedge clk) begin
        if (rst_n) begin
            if (fft_load) begin
                n_load++;
                if (q_load.size() == 0) check("load_unexpected", 64'(fft_load), 64'd0);
                else check("load_beat", {26'd0, fft_adr, fft_rd}, {26'd0, q_load.pop_front()});
            end
            if (out_we) begin
                n_we++;
                if (q_out.size() == 0) check("we_unexpected", 64'(out_we), 64'd0);
                else check("out_beat", {26'd0, out_adr, out_data}, {26'd0, q_out.pop_front()});
            end
            if (fft_start) n_start++;
            if (frame_ack) n_ack++;
            if (frame_done) n_fdone++;
            if (fft_load || fft_start || out_we)
                check("strobe_exclusive", 64'(int'(fft_load) + int'(fft_start) + int'(out_we)), 64'd1);
            if (fft_start || frame_ack)
                check("ack_with_start", 64'(frame_ack), 64'(fft_start));
        end
    end

    task automatic launch(input int ofs);
        data_ofs = ofs;
        for (int k = 0; k < NPTS; k++) q_load.push_back({6'(k), 16'(k + ofs), 16'h0000});
        ld_base = n_load; st_base = n_start; ack_base = n_ack; we_base = n_we; fd_base = n_fdone;
        frame_valid = 1'b1;
    endtask

    task automatic wait_start();
        int i;
        i = 0;
        while (!fft_start && i < 300) begin step(); i++; end
        check("fft_start_seen", 64'(fft_start), 64'd1);
        check("frame_ack_at_start", 64'(frame_ack), 64'd1);
        check("load_beats", 64'(n_load - ld_base), 64'd64);
        check("load_queue_empty", 64'(q_load.size()), 64'd0);
    endtask

    task automatic run_fft(input int hold, input bit cut, input bit keep_valid);
        int i;
        wait_start();
        if (!keep_valid) frame_valid = 1'b0;
        step();
        check("start_single_cycle", 64'(fft_start), 64'd0);
        repeat (299) step();
        for (int k = 0; k < NPTS; k++) q_out.push_back({6'(k), 16'(k), ~16'(k)});
        out_ready = (hold == 0);
        fft_done = 1'b1;
        if (hold > 0) begin
            for (int h = 0; h < hold; h++) begin
                step();
                check("no_we_in_hold", 64'(out_we), 64'd0);
            end
            out_ready = 1'b1;
            step();
            // First UNLOAD cycle: address 0 issued, nothing written yet.
            check("unload_first_cycle", {57'd0, out_we, fft_adr}, 64'd0);
            step();
            check("we_after_ready", 64'(out_we), 64'd1);
        end
        i = 0;
        while (!frame_done && i < 300) begin
            step();
            i++;
            if (cut && i == 10) begin
                fft_done  = 1'b0;
                out_ready = 1'b0;
            end
        end
        check("frame_done_seen", 64'(frame_done), 64'd1);
        check("busy_in_fin", 64'(busy), 64'd1);
        check("unload_beats", 64'(n_we - we_base), 64'd64);
        check("out_queue_empty", 64'(q_out.size()), 64'd0);
        check("frame_ack_once", 64'(n_ack - ack_base), 64'd1);
        check("fft_start_once", 64'(n_start - st_base), 64'd1);
        check("frame_done_once", 64'(n_fdone - fd_base), 64'd1);
        fft_done  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        int i;
        // Reset state.
        repeat (3) step();
        check("reset_ctrl", {39'd0, frame_ack, fft_load, fft_start, out_we, frame_done, busy, err,
                             in_adr, fft_adr, out_adr}, 64'd0);
        check("reset_fft_rd", 64'(fft_rd), 64'd0);
        check("reset_out_data", 64'(out_data), 64'd0);
        rst_n = 1'b1;
        step();
        check("idle_after_reset", {62'd0, busy, err}, 64'd0);

        // Ramp frame, out_ready already high.
        launch(0);
        step();
        check("load_first_cycle", {56'd0, busy, fft_load, in_adr}, {56'd0, 1'b1, 1'b0, 6'd0});
        run_fft(0, 1'b0, 1'b0);
        step();
        check("idle_after_fin", {62'd0, busy, frame_done}, 64'd0);

        // out_ready held low for 50 cycles after done.
        launch(37);
        run_fft(50, 1'b0, 1'b0);
        step();

        // Back-to-back frames with frame_valid held high; second drops done/ready mid-unload.
        launch(16'h100);
        run_fft(0, 1'b0, 1'b1);
        launch(16'h200);
        step();
        check("b2b_idle_gap", 64'(busy), 64'd0);
        step();
        check("b2b_second_load", {56'd0, busy, fft_load, in_adr}, {56'd0, 1'b1, 1'b0, 6'd0});
        run_fft(0, 1'b1, 1'b0);
        step();

        // Reset in the middle of LOAD.
        launch(5);
        i = 0;
        while (!(busy && in_adr == 6'd20) && i < 100) begin step(); i++; end
        check("reached_cnt20", 64'(in_adr), 64'd20);
        rst_n = 1'b0;
        frame_valid = 1'b0;
        #1;
        check("midload_reset_ctrl", {39'd0, frame_ack, fft_load, fft_start, out_we, frame_done, busy, err,
                                     in_adr, fft_adr, out_adr}, 64'd0);
        check("midload_reset_fft_rd", 64'(fft_rd), 64'd0);
        check("midload_reset_out_data", 64'(out_data), 64'd0);
        q_load.delete();
        repeat (3) step();
        check("no_ack_after_reset", 64'(n_ack - ack_base), 64'd0);
        rst_n = 1'b1;
        step();
        launch(77);
        run_fft(0, 1'b0, 1'b0);
        step();

        // FFT never finishes: timeout.
        launch(9);
        wait_start();
        frame_valid = 1'b0;
        i = 0;
        while (!err && i < TIMEOUT + 50) begin step(); i++; end
        check("timeout_latency", 64'(i), 64'(TIMEOUT));
        check("timeout_busy_low", 64'(busy), 64'd0);
        frame_valid = 1'b1;
        repeat (20) step();
        check("err_sticky", 64'(err), 64'd1);
        check("err_blocks_frames", {62'd0, busy, fft_load}, 64'd0);
        check("err_no_new_ack", 64'(n_ack - ack_base), 64'd1);
        check("err_no_restart", 64'(n_start - st_base), 64'd1);
        frame_valid = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
